pipe_chain: RTL

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain.sv | 102 ++++++++++
 1 files changed

// File: rtl/pipe_chain.sv
// pipe_chain: DEPTH-stage valid/ready register chain with bubble collapse and per-stage flush.
// Define PIPE_CHAIN_PERF_EN to add the saturating stall_cnt / bubble_cnt counters.
module pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic [DEPTH-1:0]           flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef PIPE_CHAIN_PERF_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                bubble_cnt
`endif
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] ready;
  logic [WIDTH-1:0] data_reg  [DEPTH];
  logic [WIDTH-1:0] data_next [DEPTH];
  logic [OCC_W-1:0] occ_reg;
  logic [OCC_W-1:0] occ_next;

  // A flushed entry is treated as already gone by every handshake term.
  assign live = valid_reg & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      // Unrolled ready chain: free to load if any stage from here to the output is empty, or the output pops.
      assign ready[gi] = out_ready | ~(&live[DEPTH-1:gi]);
      if (gi == 0) begin : g_head
        assign valid_next[gi] = ready[gi] ? in_valid : valid_reg[gi];
        assign data_next[gi]  = ready[gi] ? in_data  : data_reg[gi];
      end else begin : g_body
        assign valid_next[gi] = ready[gi] ? live[gi-1]     : valid_reg[gi];
        assign data_next[gi]  = ready[gi] ? data_reg[gi-1] : data_reg[gi];
      end
    end
  endgenerate

  always_comb begin
    occ_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_next = occ_next + OCC_W'(valid_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      occ_reg   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      valid_reg <= valid_next;
      occ_reg   <= occ_next;
      for (int i = 0; i < DEPTH; i++) begin
        data_reg[i] <= data_next[i];
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = live[DEPTH-1];
  assign out_data  = data_reg[DEPTH-1];
  assign occupancy = occ_reg;

`ifdef PIPE_CHAIN_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] bubble_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt_reg != 32'hFFFF_FFFF) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (out_ready && !out_valid && bubble_cnt_reg != 32'hFFFF_FFFF) begin
        bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule
